// File: rtl/maple_port_mux_if.sv
// Bundles every signal between the Maple port mux and its surroundings except clock and reset.
// slave: the mux side (takes port select, transmitter/receiver status and raw port lines; drives
// port drives, receiver lines and status). master: the controller / transceiver side.
interface maple_port_mux_if #(
  parameter int NPORTS = 4,
  parameter int SELW   = 2
);
  // transaction control and transceiver side
  logic [SELW-1:0]   port_sel;
  logic              tx_busy;
  logic              tx_sdcka;
  logic              tx_sdckb;
  logic              rx_busy;
  logic              rx_sdcka;
  logic              rx_sdckb;
  // physical port side
  logic [NPORTS-1:0] sdcka_i;
  logic [NPORTS-1:0] sdckb_i;
  logic [NPORTS-1:0] sdcka_o;
  logic [NPORTS-1:0] sdckb_o;
  logic [NPORTS-1:0] sdck_oe;
  // status
  logic              ready;
  logic [SELW-1:0]   active_port;
  logic              timeout;
  logic              sel_err;
  logic              collision;

  modport slave (
    input  port_sel, tx_busy, tx_sdcka, tx_sdckb, rx_busy, sdcka_i, sdckb_i,
    output rx_sdcka, rx_sdckb, sdcka_o, sdckb_o, sdck_oe,
    output ready, active_port, timeout, sel_err, collision
  );

  modport master (
    output port_sel, tx_busy, tx_sdcka, tx_sdckb, rx_busy, sdcka_i, sdckb_i,
    input  rx_sdcka, rx_sdckb, sdcka_o, sdckb_o, sdck_oe,
    input  ready, active_port, timeout, sel_err, collision
  );
endinterface

// File: rtl/maple_port_mux.sv
// Routes one shared Maple transmitter/receiver pair to one of NPORTS bidirectional ports per transaction.
// Latency: TX drive is combinational once in TX; port lines reach rx_sdck* after a 2-flop synchroniser.
// Backpressure: none; a tx_busy rise outside IDLE is refused and flagged with a collision pulse.
// Ports: clk/reset (sync, active-high); bus (slave modport) carries port_sel, tx_busy/tx_sdck*,
// rx_busy/rx_sdck*, per-port sdck*_i/sdck*_o/sdck_oe and the ready/active_port/timeout/sel_err/collision status.
module maple_port_mux #(
  parameter int NPORTS         = 4,
  parameter int SELW           = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int GAP_CYCLES     = 48
) (
  input  logic           clk,
  input  logic           reset,
  maple_port_mux_if.slave bus
);

  // One counter serves both the reply timeout and the idle gap, so size it for the larger.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [SELW:0] NPORTS_W = (SELW + 1)'(NPORTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT_REPLY,
    S_RX,
    S_GAP
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              tx_busy_q;
  logic              rx_busy_q;
  logic [SELW-1:0]   active_port;
  logic              ready_q;
  logic              timeout_q;
  logic              sel_err_q;
  logic              collision_q;

  logic [NPORTS-1:0] sync_a1, sync_a2;
  logic [NPORTS-1:0] sync_b1, sync_b2;

  logic              tx_rise, tx_fall, rx_rise, rx_fall;
  logic              sel_ok;
  logic [NPORTS-1:0] oe;
  logic              sel_a, sel_b;
  logic              listening;

  assign tx_rise = bus.tx_busy & ~tx_busy_q;
  assign tx_fall = ~bus.tx_busy & tx_busy_q;
  assign rx_rise = bus.rx_busy & ~rx_busy_q;
  assign rx_fall = ~bus.rx_busy & rx_busy_q;
  assign sel_ok  = {1'b0, bus.port_sel} < NPORTS_W;

  // Port lines are asynchronous to clk; idle level of the bus is 1, so reset the flops high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a1 <= '1;
      sync_a2 <= '1;
      sync_b1 <= '1;
      sync_b2 <= '1;
    end else begin
      sync_a1 <= bus.sdcka_i;
      sync_a2 <= sync_a1;
      sync_b1 <= bus.sdckb_i;
      sync_b2 <= sync_b1;
    end
  end

  // Transaction FSM. ready mirrors "next state is IDLE" so it is registered yet coincides with IDLE;
  // it is held low during reset so it first rises on the edge after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tx_busy_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
      active_port <= '0;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      tx_busy_q   <= bus.tx_busy;
      rx_busy_q   <= bus.rx_busy;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      collision_q <= 1'b0;

      // A new transmission while a transaction is in flight is only reported; nothing is routed.
      if (tx_rise && (state != S_IDLE)) begin
        collision_q <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (tx_rise) begin
            if (sel_ok) begin
              active_port <= bus.port_sel;
              state       <= S_TX;
              ready_q     <= 1'b0;
            end else begin
              sel_err_q <= 1'b1;
            end
          end
        end
        S_TX: begin
          if (tx_fall) begin
            cnt   <= '0;
            state <= S_WAIT_REPLY;
          end
        end
        S_WAIT_REPLY: begin
          // A reply arriving on the limit cycle takes priority over the timeout.
          if (rx_rise) begin
            state <= S_RX;
          end else if (cnt == TO_LAST) begin
            timeout_q <= 1'b1;
            cnt       <= '0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RX: begin
          if (rx_fall) begin
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Decode the latched port: drive enable only in TX, receive selection for the reply phases.
  always_comb begin
    oe    = '0;
    sel_a = 1'b1;
    sel_b = 1'b1;
    for (int i = 0; i < NPORTS; i++) begin
      if (active_port == SELW'(i)) begin
        oe[i] = (state == S_TX);
        sel_a = sync_a2[i];
        sel_b = sync_b2[i];
      end
    end
  end

  assign listening = (state == S_WAIT_REPLY) || (state == S_RX);

  assign bus.sdck_oe     = oe;
  assign bus.sdcka_o     = ~oe | {NPORTS{bus.tx_sdcka}};
  assign bus.sdckb_o     = ~oe | {NPORTS{bus.tx_sdckb}};
  assign bus.rx_sdcka    = listening ? sel_a : 1'b1;
  assign bus.rx_sdckb    = listening ? sel_b : 1'b1;
  assign bus.ready       = ready_q;
  assign bus.active_port = active_port;
  assign bus.timeout     = timeout_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.collision   = collision_q;

endmodule

// File: tb/tb_maple_port_mux.sv
// Bench for maple_port_mux: a 4-port instance (short timeout) and a 3-port instance for select errors.
// Transactions are described by timing (tx length, reply delay, rx length, optional collision) and the
// expected per-cycle outputs are derived from that timeline, not from any state machine.
module tb_maple_port_mux;
  localparam int TO  = 20;
  localparam int GAP = 48;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maple_port_mux_if #(.NPORTS(4), .SELW(2)) bus ();
  maple_port_mux_if #(.NPORTS(3), .SELW(2)) bus3 ();

  maple_port_mux #(.NPORTS(4), .SELW(2), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  maple_port_mux #(.NPORTS(3), .SELW(2), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  int checks;
  int errors;

  typedef struct {
    int port;
    int len;      // cycles tx_busy is high
    int dly;      // cycles from tx_busy fall to rx_busy rise; > TO means no reply
    int rlen;     // cycles rx_busy is high
    int coll;     // edge index of a second tx_busy rise, -1 for none
    bit rnd;      // random port lines instead of the directed toggle pattern
    int exp_oe;   // expected number of cycles with any drive enable
    int exp_to;   // expected timeout pulses
    int exp_rdy;  // expected edge index at which ready returns
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.port_sel  = 2'd0;
    bus.tx_busy   = 1'b0;
    bus.tx_sdcka  = 1'b1;
    bus.tx_sdckb  = 1'b1;
    bus.rx_busy   = 1'b0;
    bus.sdcka_i   = 4'hf;
    bus.sdckb_i   = 4'hf;
  endtask

  // Applies one transaction; edge t = 0 is the edge that sees tx_busy rise.
  task automatic run_txn(input int p, input int L, input int d, input int R, input int coll,
                         input bit rnd, output int n_oe, output int n_to, output int rdy_t);
    logic [3:0] hist_a [0:255];
    logic [3:0] hist_b [0:255];
    logic [3:0] a, b, exp_oe, exp_ao, exp_bo;
    logic       exp_ra, exp_rb;
    bit         reply;
    int         gs, tend;
    reply = (d <= TO);
    gs    = reply ? (L + d + R) : (L + TO);
    tend  = gs + GAP;
    n_oe  = 0;
    n_to  = 0;
    rdy_t = -1;
    for (int t = 0; t <= tend; t++) begin
      bus.port_sel = (t == 0) ? 2'(p) : 2'($urandom_range(0, 3));
      bus.tx_busy  = (t < L) || (coll >= 0 && t >= coll);
      bus.rx_busy  = reply && (t >= L + d) && (t < L + d + R);
      bus.tx_sdcka = 1'($urandom_range(0, 1));
      bus.tx_sdckb = 1'($urandom_range(0, 1));
      if (rnd) begin
        a = 4'($urandom);
        b = 4'($urandom);
      end else begin
        a = 4'hf;
        b = 4'hf;
        if (t >= L + 10) begin
          a[p] = ((t - L - 10) % 2) == 1;
          b[p] = ((t - L - 10) % 2) == 0;
        end
      end
      hist_a[t]   = a;
      hist_b[t]   = b;
      bus.sdcka_i = a;
      bus.sdckb_i = b;
      step();

      exp_oe = (t < L) ? (4'b0001 << p) : 4'b0000;
      exp_ao = ~exp_oe | {4{bus.tx_sdcka}};
      exp_bo = ~exp_oe | {4{bus.tx_sdckb}};
      exp_ra = 1'b1;
      exp_rb = 1'b1;
      if (t >= L && t < gs) begin
        exp_ra = hist_a[t-1][p];
        exp_rb = hist_b[t-1][p];
      end
      chk($sformatf("oe t=%0d", t), bus.sdck_oe, exp_oe);
      chk($sformatf("sdcka_o t=%0d", t), bus.sdcka_o, exp_ao);
      chk($sformatf("sdckb_o t=%0d", t), bus.sdckb_o, exp_bo);
      chk($sformatf("rx_sdcka t=%0d", t), bus.rx_sdcka, exp_ra);
      chk($sformatf("rx_sdckb t=%0d", t), bus.rx_sdckb, exp_rb);
      chk($sformatf("ready t=%0d", t), bus.ready, t >= tend);
      chk($sformatf("timeout t=%0d", t), bus.timeout, !reply && t == L + TO);
      chk($sformatf("collision t=%0d", t), bus.collision, coll >= 0 && t == coll);
      chk($sformatf("sel_err t=%0d", t), bus.sel_err, 0);
      chk($sformatf("active_port t=%0d", t), bus.active_port, p);
      if (bus.sdck_oe != 4'b0000) n_oe++;
      if (bus.timeout) n_to++;
      if (bus.ready && rdy_t < 0) rdy_t = t;
    end
    // Release everything; a falling tx_busy in IDLE must start nothing.
    idle_inputs();
    step();
    chk("settle ready", bus.ready, 1);
    chk("settle oe", bus.sdck_oe, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_oe, n_to, rdy_t, p, L, d, R, coll, gs;
    checks = 0;
    errors = 0;
    //          port len dly rlen coll rnd  oe  to  rdy
    vecs[0] = '{2,   40, 12, 5,   -1,  0,   40, 0,  105};  // directed port-2 transaction
    vecs[1] = '{1,   3,  25, 0,   -1,  1,   3,  1,  71};   // no reply -> timeout
    vecs[2] = '{0,   5,  20, 2,   -1,  1,   5,  0,  75};   // reply on the limit cycle wins
    vecs[3] = '{3,   2,  19, 1,   -1,  1,   2,  0,  70};
    vecs[4] = '{3,   1,  21, 0,   -1,  1,   1,  1,  69};
    vecs[5] = '{1,   4,  6,  3,   23,  1,   4,  0,  61};   // second tx_busy rise during GAP

    idle_inputs();
    bus3.port_sel = 2'd0;
    bus3.tx_busy  = 1'b0;
    bus3.tx_sdcka = 1'b1;
    bus3.tx_sdckb = 1'b1;
    bus3.rx_busy  = 1'b0;
    bus3.sdcka_i  = 3'b111;
    bus3.sdckb_i  = 3'b111;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    chk("rst oe", bus.sdck_oe, 0);
    chk("rst sdcka_o", bus.sdcka_o, 4'hf);
    chk("rst sdckb_o", bus.sdckb_o, 4'hf);
    chk("rst rx_sdcka", bus.rx_sdcka, 1);
    chk("rst rx_sdckb", bus.rx_sdckb, 1);
    chk("rst ready", bus.ready, 0);
    chk("rst active_port", bus.active_port, 0);
    chk("rst pulses", {bus.timeout, bus.sel_err, bus.collision}, 0);
    reset = 1'b0;
    step();
    chk("ready after release", bus.ready, 1);
    chk("ready3 after release", bus3.ready, 1);

    // Table of directed transactions
    foreach (vecs[i]) begin
      run_txn(vecs[i].port, vecs[i].len, vecs[i].dly, vecs[i].rlen, vecs[i].coll, vecs[i].rnd,
              n_oe, n_to, rdy_t);
      chk($sformatf("vec%0d oe cycles", i), n_oe, vecs[i].exp_oe);
      chk($sformatf("vec%0d timeouts", i), n_to, vecs[i].exp_to);
      chk($sformatf("vec%0d ready edge", i), rdy_t, vecs[i].exp_rdy);
    end

    // Randomized transactions
    for (int k = 0; k < 10; k++) begin
      p    = $urandom_range(0, 3);
      L    = $urandom_range(1, 8);
      d    = $urandom_range(1, 24);
      R    = $urandom_range(1, 6);
      gs   = (d <= TO) ? (L + d + R) : (L + TO);
      coll = ($urandom_range(0, 1) == 1) ? int'($urandom_range(L + 1, gs + GAP - 1)) : -1;
      run_txn(p, L, d, R, coll, 1'b1, n_oe, n_to, rdy_t);
      chk($sformatf("rnd%0d oe cycles", k), n_oe, L);
      chk($sformatf("rnd%0d timeouts", k), n_to, (d <= TO) ? 0 : 1);
      chk($sformatf("rnd%0d ready edge", k), rdy_t, gs + GAP);
    end

    // Out-of-range select on the 3-port instance
    bus3.port_sel = 2'd3;
    bus3.tx_busy  = 1'b1;
    step();
    chk("sel_err pulse", bus3.sel_err, 1);
    chk("sel_err oe", bus3.sdck_oe, 0);
    chk("sel_err ready", bus3.ready, 1);
    chk("sel_err sdcka_o", bus3.sdcka_o, 3'b111);
    step();
    chk("sel_err one cycle", bus3.sel_err, 0);
    chk("sel_err ready hold", bus3.ready, 1);
    bus3.tx_busy = 1'b0;
    step();
    // Highest valid port on the 3-port instance, then let it time out
    bus3.port_sel = 2'd2;
    bus3.tx_busy  = 1'b1;
    step();
    chk("p3 oe port2", bus3.sdck_oe, 3'b100);
    chk("p3 sdckb_o", bus3.sdckb_o, 3'b111);
    bus3.tx_busy = 1'b0;
    n_to = 0;
    rdy_t = -1;
    for (int c = 0; c < 150 && rdy_t < 0; c++) begin
      step();
      if (bus3.timeout) n_to++;
      if (bus3.ready) rdy_t = c;
    end
    chk("p3 timeouts", n_to, 1);
    chk("p3 ready edge", rdy_t, TO + GAP);
    chk("p3 no collision", bus3.collision, 0);
    chk("p3 rx idle", bus3.rx_sdcka & bus3.rx_sdckb, 1);
    chk("p3 active_port", bus3.active_port, 2);

    // Reset in the middle of TX releases the drive on that edge
    bus.port_sel = 2'd1;
    bus.tx_busy  = 1'b1;
    step();
    step();
    chk("midtx oe before", bus.sdck_oe, 4'b0010);
    reset = 1'b1;
    bus.tx_busy = 1'b0;
    step();
    chk("midtx oe", bus.sdck_oe, 0);
    chk("midtx sdcka_o", bus.sdcka_o, 4'hf);
    reset = 1'b0;
    step();
    chk("midtx ready", bus.ready, 1);

    // Reset in the middle of RX forces the receiver lines back to idle
    bus.port_sel = 2'd2;
    bus.tx_busy  = 1'b1;
    step();
    step();
    bus.tx_busy = 1'b0;
    step();
    bus.sdcka_i = 4'b1011;
    bus.sdckb_i = 4'b1011;
    bus.rx_busy = 1'b1;
    step();
    step();
    step();
    chk("midrx rx_sdcka before", bus.rx_sdcka, 0);
    chk("midrx rx_sdckb before", bus.rx_sdckb, 0);
    reset = 1'b1;
    step();
    chk("midrx oe", bus.sdck_oe, 0);
    chk("midrx rx_sdcka", bus.rx_sdcka, 1);
    chk("midrx rx_sdckb", bus.rx_sdckb, 1);
    reset = 1'b0;
    idle_inputs();
    step();
    chk("midrx ready", bus.ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maple_port_mux.md
MAPLE_PORT_MUX -- requirements
Module: maple_port_mux

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of Maple ports.
REQ-002 SHALL have parameter SELW, default 2, port-select width; NPORTS <= 2**SELW.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, reply wait limit in clk cycles.
REQ-004 SHALL have parameter GAP_CYCLES, default 48, post-transaction idle gap in clk cycles.
REQ-005 SHALL have ports, one per line:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- port_sel  in  SELW  target port, sampled at transaction start.
- tx_busy  in  1  transmitter busy.
- tx_sdcka, tx_sdckb  in  1 each  transmitter line outputs.
- rx_busy  in  1  receiver busy.
- rx_sdcka, rx_sdckb  out  1 each  lines to receiver.
- sdcka_i, sdckb_i  in  NPORTS each  raw per-port line inputs.
- sdcka_o, sdckb_o  out  NPORTS each  per-port line drive values.
- sdck_oe  out  NPORTS  per-port drive enable; the top level tristates, pull-up supplies idle 1.
- ready  out  1  high only in IDLE.
- active_port  out  SELW  latched port index.
- timeout  out  1  one-cycle pulse: no reply.
- sel_err  out  1  one-cycle pulse: port_sel >= NPORTS.
- collision  out  1  one-cycle pulse: tx_busy rise outside IDLE.

Function
REQ-006 SHALL run an FSM with states IDLE, TX, WAIT_REPLY, RX, GAP.
REQ-007 SHALL detect tx_busy and rx_busy rising/falling edges against a one-cycle-delayed registered copy of each.
REQ-008 IDLE: on tx_busy rise with port_sel < NPORTS, latch active_port = port_sel and enter TX on the next edge.
REQ-009 IDLE: on tx_busy rise with port_sel >= NPORTS, pulse sel_err, stay in IDLE, and drive no port.
REQ-010 TX: sdck_oe[active_port] = 1; sdcka_o/sdckb_o[active_port] follow tx_sdcka/tx_sdckb combinationally; all other oe = 0.
REQ-011 TX: on tx_busy fall, clear oe and load reply counter = 0 on the same edge; enter WAIT_REPLY.
REQ-012 SHALL pass each sdcka_i/sdckb_i bit through a 2-flop synchroniser, reset value 1.
REQ-013 In WAIT_REPLY and RX, rx_sdcka/rx_sdckb SHALL equal the synchronised lines of active_port; in all other states they SHALL be forced to 1.
REQ-014 Non-selected port inputs SHALL never reach rx_sdcka/rx_sdckb.
REQ-015 WAIT_REPLY: counter increments by 1 per cycle; on rx_busy rise, enter RX.
REQ-016 WAIT_REPLY: when counter == TIMEOUT_CYCLES-1 without rx_busy rise, pulse timeout and enter GAP.
REQ-017 WAIT_REPLY: if rx_busy rises in the same cycle the counter hits its limit, rx_busy wins and timeout SHALL NOT pulse.
REQ-018 RX: no timeout applies; on rx_busy fall, enter GAP.
REQ-019 GAP: count GAP_CYCLES cycles, then enter IDLE.
REQ-020 ready SHALL be a registered output: 1 exactly when state == IDLE.
REQ-021 A tx_busy rise in TX, WAIT_REPLY, RX or GAP SHALL pulse collision; state and oe are unchanged, and the transmitter is not driven onto any port.
REQ-022 Counter width SHALL be $clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)+1); the counter SHALL never wrap.
REQ-023 sdcka_o/sdckb_o for ports with oe = 0 SHALL be 1.
REQ-024 Pulse outputs SHALL be registered, high for exactly one cycle per event.

Reset
REQ-025 While reset = 1: state = IDLE, sdck_oe = 0, sdck*_o = all 1, rx_sdck* = 1, synchronisers = 1, counter = 0, active_port = 0, and pulse outputs = 0.
REQ-026 After reset: ready = 1 on the first edge after reset deasserts.
REQ-027 Reset asserted mid-TX SHALL release all oe on the same edge.

Verification
REQ-028 Bench SHALL cover: port_sel=2, tx_busy high 40 cycles -> oe=4'b0100 for exactly those cycles, then WAIT_REPLY.
REQ-029 Bench SHALL cover: after TX, port 2 lines toggle at cycle 10 and rx_busy rises at cycle 12 -> rx_sdck tracks port 2 with 2-cycle latency, timeout = 0, and GAP lasts 48 cycles before ready = 1.
REQ-030 Bench SHALL cover: TIMEOUT_CYCLES=20 with no rx_busy -> timeout pulses once, 20 cycles after tx_busy fall, then GAP.
REQ-031 Bench SHALL cover: NPORTS=3, port_sel=3 -> sel_err pulse, oe stays 0, ready stays 1.
REQ-032 Bench SHALL cover: a second tx_busy rise during GAP -> collision pulse, state sequence unchanged.
REQ-033 Bench SHALL cover: reset asserted mid-RX -> next edge: oe = 0, rx_sdck = 1, and ready = 1 one cycle after release.
